// File: rtl/uart_tx_fifo.sv
// Byte FIFO that decouples CPU OUT writes from the uarttx serial transmitter.
// A small drain FSM pops one byte per frame over the tx_start/tx_ready handshake.
module uart_tx_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  tx_start,
    output logic [WIDTH-1:0]      tx_byte,
    input  logic                  tx_ready
);

    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     count_q, count_d;
    logic                    overflow_q, overflow_d;
    logic                    tx_start_q, tx_start_d;
    logic [WIDTH-1:0]        tx_byte_q, tx_byte_d;
    logic [WIDTH-1:0]        mem [DEPTH];

    logic                    push_ok;
    logic                    pop;

    assign full     = (count_q == DEPTH_CNT);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign overflow = overflow_q;
    assign tx_start = tx_start_q;
    assign tx_byte  = tx_byte_q;

    // Full is judged on the registered count, so a same-cycle pop never rescues a push.
    assign push_ok = push && !full;
    assign pop     = (state_q == IDLE) && !empty && tx_ready;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (push && full);
        tx_start_d = 1'b0;
        tx_byte_d  = tx_byte_q;

        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d    = START;
                    tx_start_d = 1'b1;
                    tx_byte_d  = mem[rd_ptr_q];
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                end
            end
            START:     state_d = WAIT_BUSY;
            WAIT_BUSY: if (!tx_ready) state_d = WAIT_DONE;
            WAIT_DONE: if (tx_ready) state_d = IDLE;
            default:   state_d = IDLE;
        endcase

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_start_q <= 1'b0;
            tx_byte_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_start_q <= tx_start_d;
            tx_byte_q  <= tx_byte_d;
        end
    end

    // Storage needs no reset; pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a vector table for cycle-exact handshake
// behaviour plus sequences for fill/overflow, pointer wrap and mid-frame reset.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push = 1'b0;
    logic [7:0] push_data = 8'h00;
    logic       full, empty, overflow, tx_start, tx_ready;
    logic [3:0] count;
    logic [7:0] tx_byte;

    logic       model_en = 1'b0;
    logic       ready_force = 1'b1;
    logic       model_ready = 1'b1;
    int         busy_len = 10;
    int         busy = 0;
    logic [7:0] rx_q [$];

    int n_chk = 0;
    int n_fail = 0;

    uart_tx_fifo #(.WIDTH(8), .DEPTH_LOG2(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .tx_start  (tx_start),
        .tx_byte   (tx_byte),
        .tx_ready  (tx_ready)
    );

    always #5 clk = ~clk;

    assign tx_ready = model_en ? model_ready : ready_force;

    // uarttx stand-in: goes busy for busy_len cycles after each start pulse; logs every pulse
    always @(negedge clk) begin
        if (tx_start) rx_q.push_back(tx_byte);
        if (!model_en) begin
            busy = 0;
            model_ready = 1'b1;
        end else if (tx_start) begin
            busy = busy_len;
            model_ready = 1'b0;
        end else if (busy > 0) begin
            busy = busy - 1;
            if (busy == 0) model_ready = 1'b1;
        end else begin
            model_ready = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        push = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic       push;
        logic [7:0] data;
        logic       rdy;
        logic [3:0] cnt;
        logic       full;
        logic       empty;
        logic       ts;
        logic [7:0] tbyte;
        logic       ovf;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int base;
        int nxt;

        // push, data, rdy | count, full, empty, tx_start, tx_byte, overflow
        vecs[0] = '{1'b1, 8'h41, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 8'h41, 1'b0};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 8'h41, 1'b0};
        vecs[3] = '{1'b1, 8'h55, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 8'h41, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 8'h41, 1'b0};
        vecs[5] = '{1'b1, 8'h66, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 8'h41, 1'b0};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 8'h41, 1'b0};
        vecs[7] = '{1'b1, 8'h77, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0};

        // Reset with push held high
        push = 1'b1;
        push_data = 8'hAA;
        repeat (3) @(negedge clk);
        chk("rst_count_during", 32'(count), 32'd0);
        rst = 1'b0;
        push = 1'b0;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_byte", 32'(tx_byte), 32'd0);

        // Cycle-exact table: single byte latency, then push/pop overlap
        model_en = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            push = vecs[i].push;
            push_data = vecs[i].data;
            ready_force = vecs[i].rdy;
            edge_settle();
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].full));
            chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].empty));
            chk($sformatf("vec%0d_tx_start", i), 32'(tx_start), 32'(vecs[i].ts));
            chk($sformatf("vec%0d_tx_byte", i), 32'(tx_byte), 32'(vecs[i].tbyte));
            chk($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].ovf));
        end

        // Eight consecutive pushes drained by a 10-cycle transmitter
        do_reset();
        model_en = 1'b1;
        busy_len = 10;
        base = rx_q.size();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            push = 1'b1;
            push_data = 8'h10 + 8'(i);
        end
        @(negedge clk);
        push = 1'b0;
        repeat (200) @(negedge clk);
        chk("burst_pulses", 32'(rx_q.size() - base), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (base + i < rx_q.size())
                chk($sformatf("burst_byte%0d", i), 32'(rx_q[base + i]), 32'h10 + 32'(i));
        end
        chk("burst_overflow", 32'(overflow), 32'd0);
        chk("burst_empty", 32'(empty), 32'd1);

        // Fill with transmitter stalled, then overflow and push-during-pop while full
        do_reset();
        model_en = 1'b0;
        ready_force = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            push = 1'b1;
            push_data = 8'h20 + 8'(i);
            edge_settle();
            if (i == 7) begin
                chk("fill8_full", 32'(full), 32'd1);
                chk("fill8_count", 32'(count), 32'd8);
                chk("fill8_overflow", 32'(overflow), 32'd0);
            end
        end
        chk("fill9_count", 32'(count), 32'd8);
        chk("fill9_overflow", 32'(overflow), 32'd1);
        @(negedge clk);
        push = 1'b1;
        push_data = 8'h30;
        ready_force = 1'b1;
        edge_settle();
        chk("fullpop_count", 32'(count), 32'd7);
        chk("fullpop_tx_start", 32'(tx_start), 32'd1);
        chk("fullpop_tx_byte", 32'(tx_byte), 32'h20);
        @(negedge clk);
        push = 1'b0;
        edge_settle();
        chk("overflow_sticky", 32'(overflow), 32'd1);

        // Fill, then drain and refill across the pointer wrap (20 bytes)
        do_reset();
        model_en = 1'b0;
        ready_force = 1'b0;
        base = rx_q.size();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            push = 1'b1;
            push_data = 8'h80 + 8'(i);
        end
        @(negedge clk);
        push = 1'b0;
        chk("wrap_full", 32'(full), 32'd1);
        busy_len = 3;
        model_en = 1'b1;
        nxt = 8;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (nxt < 20 && !full) begin
                push = 1'b1;
                push_data = 8'h80 + 8'(nxt);
                nxt++;
            end else begin
                push = 1'b0;
            end
        end
        chk("wrap_pulses", 32'(rx_q.size() - base), 32'd20);
        for (int i = 0; i < 20; i++) begin
            if (base + i < rx_q.size())
                chk($sformatf("wrap_byte%0d", i), 32'(rx_q[base + i]), 32'h80 + 32'(i));
        end
        chk("wrap_overflow", 32'(overflow), 32'd0);

        // Reset while stuck in WAIT_BUSY with three bytes queued
        do_reset();
        model_en = 1'b0;
        ready_force = 1'b1;
        base = rx_q.size();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            push = 1'b1;
            push_data = 8'hC0 + 8'(i);
            edge_settle();
        end
        chk("midrst_count_before", 32'(count), 32'd3);
        chk("midrst_tx_start_before", 32'(tx_start), 32'd0);
        @(negedge clk);
        push = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_empty", 32'(empty), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("midrst_no_start", 32'(rx_q.size() - base), 32'd1);
        push = 1'b1;
        push_data = 8'hE5;
        @(negedge clk);
        push = 1'b0;
        repeat (6) @(negedge clk);
        chk("midrst_new_pulse", 32'(rx_q.size() - base), 32'd2);
        if (rx_q.size() > 0)
            chk("midrst_new_byte", 32'(rx_q[rx_q.size() - 1]), 32'hE5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
